// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared widths, defaults and loader state enum for ADPLL control blocks
package adpll_pkg;

    localparam int PARAM_W        = 3;
    localparam int VAL_W          = 5;
    localparam int CMD_W          = PARAM_W + VAL_W;
    localparam int NUM_PARAMS_DEF = 6;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_CLEAR  = 3'd1,
        LD_SETUP  = 3'd2,
        LD_STROBE = 3'd3,
        LD_HOLD   = 3'd4
    } ld_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adpll_param_loader_if.sv
// rtl/adpll_param_loader_if.sv - command port and ADPLL programming bus of the parameter loader
interface adpll_param_loader_if;
    import adpll_pkg::*;

    logic               wr_valid;
    logic               wr_ready;
    logic [PARAM_W-1:0] wr_param;
    logic [VAL_W-1:0]   wr_value;
    logic               clr_req;
    logic               clr;
    logic               pgm;
    logic [PARAM_W-1:0] param_sel;
    logic [VAL_W-1:0]   pgm_value;
    logic               busy;
    logic               done;
    logic               err;

    // host / control side issuing commands
    modport master (
        output wr_valid, wr_param, wr_value, clr_req,
        input  wr_ready, clr, pgm, param_sel, pgm_value, busy, done, err
    );

    // loader side driving the ADPLL programming pins
    modport slave (
        input  wr_valid, wr_param, wr_value, clr_req,
        output wr_ready, clr, pgm, param_sel, pgm_value, busy, done, err
    );

endinterface

// File: rtl/adpll_cmd_fifo.sv
// rtl/adpll_cmd_fifo.sv - synchronous {param, value} command FIFO with flush
module adpll_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    input  logic         flush,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // flush wins over a same-cycle push so a clear discards everything queued
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // entry storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/adpll_param_loader.sv
// rtl/adpll_param_loader.sv - replays queued parameter writes as framed pgm strobes and issues clr pulses
module adpll_param_loader
    import adpll_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_PARAMS = NUM_PARAMS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adpll_param_loader_if.slave  ctl
);

    localparam int CNT_MAX = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]   PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [PARAM_W:0]   NP_LIM   = (PARAM_W+1)'(NUM_PARAMS);

    ld_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               clr_q, pgm_q, busy_q, done_q;
    logic [PARAM_W-1:0] param_sel_q;
    logic [VAL_W-1:0]   pgm_value_q;
    logic               clr_pend_q, clr_pend_d;
    logic               err_q, err_d;
    logic               rdy_q;

    logic               fifo_full, fifo_empty;
    logic [CMD_W-1:0]   fifo_rd_data;
    logic               accept, legal, push, pop;
    logic               seq_end, decide, enter_clear;

    assign accept  = ctl.wr_valid & ctl.wr_ready;
    assign legal   = ({1'b0, ctl.wr_param} < NP_LIM);
    assign push    = accept & legal;

    // a write sequence ends after HOLD, or straight after STROBE when there is no hold phase
    assign seq_end = ((state_q == LD_HOLD) && (cnt_q == '0)) ||
                     ((state_q == LD_STROBE) && (cnt_q == '0) && (HOLD_CYC == 0));
    assign decide      = (state_q == LD_IDLE) || seq_end;
    assign enter_clear = decide & clr_pend_q;
    assign pop         = decide & ~clr_pend_q & ~fifo_empty;

    assign clr_pend_d = enter_clear ? 1'b0 : (clr_pend_q | ctl.clr_req);
    assign err_d      = enter_clear ? 1'b0 : (err_q | (accept & ~legal));

    assign ctl.wr_ready  = rdy_q & ~fifo_full;
    assign ctl.clr       = clr_q;
    assign ctl.pgm       = pgm_q;
    assign ctl.param_sel = param_sel_q;
    assign ctl.pgm_value = pgm_value_q;
    assign ctl.busy      = busy_q;
    assign ctl.done      = done_q;
    assign ctl.err       = err_q;

    adpll_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({ctl.wr_param, ctl.wr_value}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .flush   (enter_clear),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // pending-clear and sticky-error flags; ready is held low until the first cycle after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_pend_q <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            clr_pend_q <= clr_pend_d;
            err_q      <= err_d;
            rdy_q      <= 1'b1;
        end
    end

    // sequencing FSM; every pin toward the ADPLL is registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            cnt_q       <= '0;
            clr_q       <= 1'b0;
            pgm_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            param_sel_q <= '0;
            pgm_value_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (enter_clear) begin
                state_q     <= LD_CLEAR;
                cnt_q       <= PULSE_LD;
                clr_q       <= 1'b1;
                pgm_q       <= 1'b0;
                busy_q      <= 1'b1;
                param_sel_q <= '0;
                pgm_value_q <= '0;
            end else if (pop) begin
                state_q     <= LD_SETUP;
                cnt_q       <= SETUP_LD;
                pgm_q       <= 1'b0;
                busy_q      <= 1'b1;
                param_sel_q <= fifo_rd_data[CMD_W-1:VAL_W];
                pgm_value_q <= fifo_rd_data[VAL_W-1:0];
            end else if (seq_end) begin
                state_q <= LD_IDLE;
                pgm_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    LD_SETUP: begin
                        if (cnt_q == '0) begin
                            state_q <= LD_STROBE;
                            cnt_q   <= PULSE_LD;
                            pgm_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    LD_STROBE: begin
                        if (cnt_q == '0) begin
                            state_q <= LD_HOLD;
                            cnt_q   <= HOLD_LD;
                            pgm_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    LD_HOLD: begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    LD_CLEAR: begin
                        if (cnt_q == '0) begin
                            state_q <= LD_IDLE;
                            clr_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= LD_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adpll_param_loader.sv
// tb/tb_adpll_param_loader.sv - self-checking bench for adpll_param_loader
module tb_adpll_param_loader;
    import adpll_pkg::*;

    localparam int PULSE = 2;
    localparam int NPAR  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    adpll_param_loader_if ctl();

    adpll_param_loader #(
        .SETUP_CYC  (2),
        .PULSE_CYC  (2),
        .HOLD_CYC   (1),
        .FIFO_DEPTH (4),
        .NUM_PARAMS (NPAR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state: commands owed to the ADPLL, in order
    logic [7:0] exp_q[$];
    int         gaps[$];
    logic       err_model = 1'b0;
    int n_pulse = 0, n_clr = 0, n_done = 0, n_bfall = 0;
    logic pgm_prev = 0, clr_prev = 0, busy_prev = 0, busy_cont = 0;
    int   pgm_w = 0, clr_w = 0, low_cnt = 0;
    logic [7:0] sel_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: checks strobe framing and replays accepted commands against the model queue
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            err_model = 1'b0;
            pgm_prev = 0; clr_prev = 0; busy_prev = 0; busy_cont = 0;
            pgm_w = 0; clr_w = 0; low_cnt = 0;
        end else begin
            if (ctl.clr && !clr_prev) begin
                exp_q.delete();
                err_model = 1'b0;
                n_clr++;
            end
            if (ctl.clr) clr_w++;
            else if (clr_prev) begin
                chk("clr_width", clr_w, PULSE);
                clr_w = 0;
            end
            chk("clr_pgm_excl", {31'd0, ctl.clr & ctl.pgm}, 0);
            chk("err_flag", {31'd0, ctl.err}, {31'd0, err_model});
            if (ctl.pgm && !pgm_prev) begin
                n_pulse++;
                if (busy_cont) gaps.push_back(low_cnt);
                chk("setup_stable", {24'd0, ctl.param_sel, ctl.pgm_value}, {24'd0, sel_prev});
                if (exp_q.size() == 0) chk("spurious_pgm", 1, 0);
                else begin
                    chk("pgm_cmd", {24'd0, ctl.param_sel, ctl.pgm_value}, {24'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
            end
            if (ctl.pgm) pgm_w++;
            else begin
                if (pgm_prev) begin
                    chk("pgm_width", pgm_w, PULSE);
                    pgm_w = 0;
                    busy_cont = 1;
                    low_cnt = 0;
                end
                low_cnt++;
            end
            if (!ctl.busy) busy_cont = 0;
            if (ctl.done) n_done++;
            if (busy_prev && !ctl.busy) n_bfall++;
            if (ctl.wr_valid && ctl.wr_ready) begin
                if (int'(ctl.wr_param) < NPAR) exp_q.push_back({ctl.wr_param, ctl.wr_value});
                else err_model = 1'b1;
            end
            pgm_prev  = ctl.pgm;
            clr_prev  = ctl.clr;
            busy_prev = ctl.busy;
            sel_prev  = {ctl.param_sel, ctl.pgm_value};
        end
    end

    task automatic send_cmd(input logic [2:0] p, input logic [4:0] v);
        logic ok;
        ok = 1'b0;
        ctl.wr_valid = 1'b1;
        ctl.wr_param = p;
        ctl.wr_value = v;
        for (int i = 0; i < 60; i++) begin
            if (ctl.wr_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        ctl.wr_valid = 1'b0;
        chk("send_accepted", {31'd0, ok}, 1);
    endtask

    task automatic wait_idle();
        int idle;
        idle = 0;
        for (int i = 0; i < 400 && idle < 3; i++) begin
            tick();
            if (!ctl.busy) idle++;
            else idle = 0;
        end
        chk("drain_timeout", {31'd0, idle >= 3}, 1);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic wait_pgm();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ctl.pgm) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_pgm", {31'd0, seen}, 1);
    endtask

    task automatic pulse_clr_req();
        ctl.clr_req = 1'b1;
        tick();
        ctl.clr_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e_pgm, e_busy, e_done;
        int p0, c0, d0, b0, legal_n, illegal_n;
        logic [2:0] rp;

        ctl.wr_valid = 0; ctl.wr_param = 0; ctl.wr_value = 0; ctl.clr_req = 0;

        // reset state
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_ready", {31'd0, ctl.wr_ready}, 0);
        chk("rst_busy", {31'd0, ctl.busy}, 0);
        chk("rst_pgm_clr", {30'd0, ctl.pgm, ctl.clr}, 0);
        chk("rst_sel", {24'd0, ctl.param_sel, ctl.pgm_value}, 0);
        chk("rst_err_done", {30'd0, ctl.err, ctl.done}, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", {31'd0, ctl.wr_ready}, 1);
        tick();

        // single write timing
        e_pgm  = 8'b0001_1000;
        e_busy = 8'b0011_1110;
        e_done = 8'b0100_0000;
        send_cmd(3'd2, 5'd17);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t1_pgm_c%0d", c), {31'd0, ctl.pgm}, {31'd0, e_pgm[c]});
            chk($sformatf("t1_busy_c%0d", c), {31'd0, ctl.busy}, {31'd0, e_busy[c]});
            chk($sformatf("t1_done_c%0d", c), {31'd0, ctl.done}, {31'd0, e_done[c]});
            if (c >= 1) chk($sformatf("t1_sel_c%0d", c), {24'd0, ctl.param_sel, ctl.pgm_value}, {24'd0, 3'd2, 5'd17});
            tick();
        end
        wait_idle();

        // three back-to-back writes
        gaps.delete();
        p0 = n_pulse; d0 = n_done; b0 = n_bfall;
        send_cmd(3'd0, 5'd1);
        send_cmd(3'd1, 5'd30);
        send_cmd(3'd5, 5'd12);
        wait_idle();
        chk("t2_pulses", n_pulse - p0, 3);
        chk("t2_done", n_done - d0, 1);
        chk("t2_busy_cont", n_bfall - b0, 1);
        chk("t2_ngaps", gaps.size(), 2);
        foreach (gaps[i]) chk($sformatf("t2_gap%0d", i), gaps[i], 3);

        // FIFO fill: ready drops once four are stored
        p0 = n_pulse;
        send_cmd(3'd0, 5'd3);
        send_cmd(3'd1, 5'd4);
        send_cmd(3'd2, 5'd5);
        send_cmd(3'd3, 5'd6);
        chk("t3_ready_3stored", {31'd0, ctl.wr_ready}, 1);
        send_cmd(3'd4, 5'd7);
        chk("t3_full", {31'd0, ctl.wr_ready}, 0);
        send_cmd(3'd5, 5'd8);
        wait_idle();
        chk("t3_pulses", n_pulse - p0, 6);

        // illegal parameter code, then clear
        p0 = n_pulse; c0 = n_clr; d0 = n_done;
        send_cmd(3'd7, 5'd9);
        wait_idle();
        chk("t4_no_pgm", n_pulse - p0, 0);
        chk("t4_err_set", {31'd0, ctl.err}, 1);
        pulse_clr_req();
        wait_idle();
        chk("t4_err_clr", {31'd0, ctl.err}, 0);
        chk("t4_clr_cnt", n_clr - c0, 1);
        chk("t4_sel_zero", {24'd0, ctl.param_sel, ctl.pgm_value}, 0);

        // clear during STROBE with two queued
        p0 = n_pulse; c0 = n_clr; d0 = n_done;
        send_cmd(3'd1, 5'd21);
        send_cmd(3'd2, 5'd22);
        send_cmd(3'd3, 5'd23);
        wait_pgm();
        pulse_clr_req();
        wait_idle();
        chk("t5_pulses", n_pulse - p0, 1);
        chk("t5_clr_cnt", n_clr - c0, 1);
        chk("t5_done", n_done - d0, 1);

        // reset mid-STROBE
        send_cmd(3'd4, 5'd10);
        wait_pgm();
        rst_n = 1'b0;
        tick();
        chk("t6_pgm", {31'd0, ctl.pgm}, 0);
        chk("t6_busy", {31'd0, ctl.busy}, 0);
        chk("t6_ready_rst", {31'd0, ctl.wr_ready}, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_ready_rel", {31'd0, ctl.wr_ready}, 1);
        p0 = n_pulse;
        send_cmd(3'd1, 5'd9);
        wait_idle();
        chk("t6_pulses", n_pulse - p0, 1);

        // randomized command stream
        p0 = n_pulse; legal_n = 0; illegal_n = 0;
        for (int k = 0; k < 40; k++) begin
            rp = 3'($urandom_range(0, 7));
            if (int'(rp) < NPAR) legal_n++;
            else illegal_n++;
            send_cmd(rp, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        chk("rnd_pulses", n_pulse - p0, legal_n);
        chk("rnd_err", {31'd0, ctl.err}, {31'd0, illegal_n > 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
